regfile_param: RTL and testbench

Parametrised multi-cycle-initialised register file, the successor to the fixed 32x64 datapath register file. Provides two registered read ports and one write port with a configurable width and depth, a hardwired zero register, and a hardware clear sequencer that loads every entry with its own index after reset. It sits between decode (read addresses) and writeback (write port) in the RISC-V datapath. A `ready` flag gates the pipeline until initialisation completes.

---
 rtl/regfile_param.sv | 128 ++++++++++++
 tb/tb_regfile_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two registered read ports, one write port, optional hardwired zero
// register and a clear sequencer that loads each entry with its index. Macro: REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [WIDTH-1:0]  writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2,
  output logic              ready
);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic [WIDTH-1:0]  rd1_q, rd1_d;
  logic [WIDTH-1:0]  rd2_q, rd2_d;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [WIDTH-1:0]  mem_wdata_c;
  logic              wr_ok_c;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // A RUN-state write that actually lands in the array (also qualifies the bypass)
  always_comb begin : write_qual
    wr_ok_c = regWrite && in_range(writeReg) && !is_zero_reg(writeReg);
  end

  // Sequencer: CLEAR walks every entry once, then hands the write port to the pipeline
  always_comb begin : next_state
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    ready_d     = ready_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = writeReg;
    mem_wdata_c = writeData;
    case (state_q)
      CLEAR: begin
        mem_we_c    = ~reset;
        mem_waddr_c = clr_idx_q;
        mem_wdata_c = WIDTH'(clr_idx_q);
        if (clr_idx_q == LAST_IDX) begin
          state_d   = RUN;
          ready_d   = 1'b1;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      RUN: begin
        mem_we_c = wr_ok_c;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Read muxes: zero while clearing, for out-of-range and for the hardwired zero register
  always_comb begin : read_mux
    rd1_d = '0;
    rd2_d = '0;
    if (state_q == RUN) begin
      if (in_range(readReg1) && !is_zero_reg(readReg1)) begin
        rd1_d = (BYPASS && wr_ok_c && (writeReg == readReg1)) ? writeData : mem_q[readReg1];
      end
      if (in_range(readReg2) && !is_zero_reg(readReg2)) begin
        rd2_d = (BYPASS && wr_ok_c && (writeReg == readReg2)) ? writeData : mem_q[readReg2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin : ctrl_regs
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
    end
  end

  // Array contents survive reset; only the sequencer rewrites them
  always_ff @(posedge clk) begin : array_write
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  assign readData1 = rd1_q;
  assign readData2 = rd2_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed steps plus random traffic against an array model,
// on a default instance and a narrow ZERO_REG=0, DEPTH=20 instance sharing the same stimulus.
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        regWrite = 1'b0;
  logic [4:0]  writeReg = '0;
  logic [63:0] writeData = '0;
  logic [4:0]  readReg1 = '0;
  logic [4:0]  readReg2 = '0;
  logic [63:0] rdA1, rdA2;
  logic        readyA;
  logic [15:0] rdB1, rdB2;
  logic        readyB;

  int n_chk = 0;
  int n_fail = 0;
  int k = 0;
  logic [63:0] mdl [2][32];

  always #5 clk = ~clk;

  regfile_param u_dut_a (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(rdA1), .readData2(rdA2), .ready(readyA)
  );

  regfile_param #(.WIDTH(16), .DEPTH(20), .ADDR_W(5), .ZERO_REG(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData[15:0]),
    .readReg1(readReg1), .readReg2(readReg2), .readData1(rdB1), .readData2(rdB2), .ready(readyB)
  );

  function automatic int dep(input int i);
    return (i == 0) ? 32 : 20;
  endfunction

  function automatic bit zr(input int i);
    return i == 0;
  endfunction

  function automatic logic [63:0] msk(input int i);
    return (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
  endfunction

  function automatic bit wr_ok(input int i);
    return regWrite && (int'(writeReg) < dep(i)) && !(zr(i) && writeReg == 5'd0);
  endfunction

  function automatic logic [63:0] rd_exp(input int i, input logic [4:0] a);
    if (k < dep(i)) return 64'd0;
    if (int'(a) >= dep(i) || (zr(i) && a == 5'd0)) return 64'd0;
    if (BYP && wr_ok(i) && writeReg == a) return writeData & msk(i);
    return mdl[i][a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock with reset low: predict, clock, compare, then advance the model
  task automatic step();
    logic [63:0] e [2][3];
    for (int i = 0; i < 2; i++) begin
      e[i][0] = rd_exp(i, readReg1);
      e[i][1] = rd_exp(i, readReg2);
      e[i][2] = (k + 1 >= dep(i)) ? 64'd1 : 64'd0;
    end
    @(posedge clk);
    #1;
    chk("a_rd1", rdA1, e[0][0]);
    chk("a_rd2", rdA2, e[0][1]);
    chk("a_ready", {63'd0, readyA}, e[0][2]);
    chk("b_rd1", {48'd0, rdB1}, e[1][0]);
    chk("b_rd2", {48'd0, rdB2}, e[1][1]);
    chk("b_ready", {63'd0, readyB}, e[1][2]);
    for (int i = 0; i < 2; i++) begin
      if (k < dep(i)) mdl[i][k] = 64'(k) & msk(i);
      else if (wr_ok(i)) mdl[i][writeReg] = writeData & msk(i);
    end
    if (k < 100000) k++;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_rd1"}, rdA1, 64'd0);
    chk({tag, "_a_rd2"}, rdA2, 64'd0);
    chk({tag, "_a_ready"}, {63'd0, readyA}, 64'd0);
    chk({tag, "_b_rd1"}, {48'd0, rdB1}, 64'd0);
    chk({tag, "_b_ready"}, {63'd0, readyB}, 64'd0);
  endtask

  // Asserted mid-cycle so the clear is seen before any clock edge
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic idle();
    regWrite = 1'b0;
    writeReg = '0;
    writeData = '0;
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);

    // Interrupt the clear sequence at its tenth cycle
    for (int c = 0; c < 10; c++) begin
      readReg1 = 5'($urandom);
      readReg2 = 5'($urandom);
      step();
    end
    do_reset(2);

    // Full clear, with a write to reg 3 attempted at cycle 2
    for (int c = 0; c < 32; c++) begin
      readReg1 = 5'($urandom);
      readReg2 = 5'($urandom);
      if (c == 2) begin
        regWrite = 1'b1;
        writeReg = 5'd3;
        writeData = 64'hFF;
      end else begin
        idle();
      end
      step();
    end
    idle();
    chk("ready_after_32", {63'd0, readyA}, 64'd1);

    readReg1 = 5'd5;
    readReg2 = 5'd31;
    step();
    chk("init_reg5", rdA1, 64'd5);
    chk("init_reg31", rdA2, 64'd31);
    readReg1 = 5'd3;
    step();
    chk("clear_write_ignored", rdA1, 64'd3);

    regWrite = 1'b1;
    writeReg = 5'd7;
    writeData = 64'hDEAD_BEEF;
    readReg1 = 5'd1;
    step();
    idle();
    readReg1 = 5'd7;
    step();
    chk("reg7_deadbeef", rdA1, 64'hDEAD_BEEF);

    regWrite = 1'b1;
    writeReg = 5'd0;
    writeData = 64'h1234;
    step();
    idle();
    readReg1 = 5'd0;
    readReg2 = 5'd0;
    step();
    chk("zero_reg_a", rdA1, 64'd0);
    chk("zero_reg_b", {48'd0, rdB1}, 64'h1234);

    regWrite = 1'b1;
    writeReg = 5'd9;
    writeData = 64'hAA;
    readReg1 = 5'd9;
    readReg2 = 5'd9;
    step();
    chk("same_cycle_p1", rdA1, BYP ? 64'hAA : 64'd9);
    chk("same_cycle_p2", rdA2, BYP ? 64'hAA : 64'd9);
    idle();
    step();
    chk("after_same_cycle", rdA1, 64'hAA);

    readReg1 = 5'd25;
    step();
    chk("b_out_of_range", {48'd0, rdB1}, 64'd0);

    // Random traffic, addresses biased toward a few registers to provoke collisions
    for (int c = 0; c < 400; c++) begin
      regWrite = 1'($urandom);
      writeReg = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      writeData = {$urandom, $urandom};
      readReg1 = ($urandom_range(0, 2) == 0) ? writeReg : 5'($urandom);
      readReg2 = ($urandom_range(0, 3) == 0) ? readReg1 : 5'($urandom);
      step();
    end

    // Reset from RUN reruns the clear, overwriting everything
    idle();
    do_reset(1);
    for (int c = 0; c < 36; c++) begin
      readReg1 = 5'($urandom);
      readReg2 = 5'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
